// File: rtl/vec_enc_pkg.sv
// Shared definitions for the vector-to-index encoder: FSM states and index width helper.
package vec_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } vec_enc_state_t;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vec_enc_pri_enc.sv
// Combinational lowest-set-bit priority encoder; o_any flags a non-zero input.
module pri_enc
    import vec_enc_pkg::*;
#(
    parameter int N = 16,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] i_x,
    output logic [W-1:0] o_y,
    output logic         o_any
);

    // Scan from the top so the lowest set bit is the final assignment.
    always_comb begin
        o_y   = '0;
        o_any = |i_x;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_x[i]) begin
                o_y = W'(i);
            end
        end
    end

endmodule

// File: rtl/vec_enc.sv
// Serialises a multi-hot vector into one index per beat, lowest first; first beat the cycle after accept.
// Downstream stall holds the current beat; a new vector may be accepted on the last beat with no bubble.
module vec_enc
    import vec_enc_pkg::*;
#(
    parameter int N = 16,
    localparam int W = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_vld,
    input  logic [N-1:0] i_vec,
    output logic         o_rdy,
    output logic         o_vld,
    output logic [W-1:0] o_idx,
    output logic         o_last,
    input  logic         i_rdy,
    output logic         o_busy
);

    vec_enc_state_t state;
    logic [N-1:0]   residue;
    logic [N-1:0]   residue_next;
    logic [W-1:0]   low_idx;
    logic           low_any;
    logic           emit;
    logic           is_last;
    logic           accept;
    logic           beat;

    pri_enc #(.N(N)) u_pri_enc (
        .i_x   (residue),
        .o_y   (low_idx),
        .o_any (low_any)
    );

    assign residue_next = residue & (residue - N'(1));
    assign is_last      = (residue_next == '0);

    // Outputs are masked by rst so nothing stale is visible during the reset cycle.
    assign emit   = (state == EMIT) && !rst;
    assign o_vld  = emit;
    assign o_busy = emit;
    assign o_idx  = (emit && low_any) ? low_idx : '0;
    assign o_last = emit && is_last;
    assign o_rdy  = !rst && ((state == IDLE) || (is_last && i_rdy));

    assign accept = i_vld && o_rdy;
    assign beat   = o_vld && i_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            residue <= '0;
        end else if (accept) begin
            residue <= i_vec;
            state   <= (i_vec != '0) ? EMIT : IDLE;
        end else if (beat) begin
            residue <= residue_next;
            if (is_last) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_vec_enc.sv
// Self-checking bench for vec_enc (N=8): directed scenarios plus randomized traffic against a queue model.
module tb_vec_enc;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         i_vld;
    logic [N-1:0] i_vec;
    logic         o_rdy;
    logic         o_vld;
    logic [W-1:0] o_idx;
    logic         o_last;
    logic         i_rdy;
    logic         o_busy;

    int checks;
    int errors;

    vec_enc #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (i_vld),
        .i_vec  (i_vec),
        .o_rdy  (o_rdy),
        .o_vld  (o_vld),
        .o_idx  (o_idx),
        .o_last (o_last),
        .i_rdy  (i_rdy),
        .o_busy (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept a vector: drive it, confirm o_rdy at mid-cycle, cross the edge, drop i_vld.
    task automatic offer(input logic [N-1:0] v);
        i_vld = 1'b1;
        i_vec = v;
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL offer_rdy vec=%h got o_rdy=%b want 1", v, o_rdy);
        end
        tick();
        i_vld = 1'b0;
        i_vec = $urandom;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        i_vld = 1'b1;
        i_vec = 8'hFF;
        i_rdy = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({o_vld, o_rdy, o_busy, o_idx, o_last} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got vld=%b rdy=%b busy=%b idx=%0d last=%b want all 0",
                     o_vld, o_rdy, o_busy, o_idx, o_last);
        end
        tick();
        rst   = 1'b0;
        i_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b1 || o_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", o_rdy, o_vld);
        end
        tick();
    endtask

    task automatic test_single;
        i_rdy = 1'b1;
        offer(8'b0000_0100);
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b1 || o_idx !== 3'd2 || o_last !== 1'b1 || o_rdy !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_beat got vld=%b idx=%0d last=%b rdy=%b busy=%b want 1 2 1 1 1",
                     o_vld, o_idx, o_last, o_rdy, o_busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_done got vld=%b want 0", o_vld);
        end
        tick();
    endtask

    task automatic test_multi;
        logic [W-1:0] exp_idx [3];
        logic         exp_last[3];
        exp_idx  = '{3'd1, 3'd4, 3'd7};
        exp_last = '{1'b0, 1'b0, 1'b1};
        i_rdy = 1'b1;
        offer(8'b1001_0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (o_vld !== 1'b1 || o_idx !== exp_idx[k] || o_last !== exp_last[k]) begin
                errors++;
                $display("FAIL multi_beat%0d got vld=%b idx=%0d last=%b want 1 %0d %b",
                         k, o_vld, o_idx, o_last, exp_idx[k], exp_last[k]);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL multi_done got vld=%b want 0", o_vld);
        end
        tick();
    endtask

    task automatic test_backpressure;
        i_rdy = 1'b1;
        offer(8'b1001_0010);
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b1 || o_idx !== 3'd1) begin
            errors++;
            $display("FAIL bp_first got vld=%b idx=%0d want 1 1", o_vld, o_idx);
        end
        tick();
        i_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            i_vld = 1'b1;
            i_vec = 8'hFF;
            @(negedge clk);
            checks++;
            if (o_vld !== 1'b1 || o_idx !== 3'd4 || o_last !== 1'b0 || o_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got vld=%b idx=%0d last=%b rdy=%b want 1 4 0 0",
                         k, o_vld, o_idx, o_last, o_rdy);
            end
            tick();
        end
        i_vld = 1'b0;
        i_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b1 || o_idx !== 3'd4 || o_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_resume got vld=%b idx=%0d last=%b want 1 4 0", o_vld, o_idx, o_last);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b1 || o_idx !== 3'd7 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_tail got vld=%b idx=%0d last=%b want 1 7 1", o_vld, o_idx, o_last);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL bp_done got vld=%b want 0", o_vld);
        end
        tick();
    endtask

    task automatic test_zero_then_ones;
        i_rdy = 1'b1;
        offer(8'h00);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (o_vld !== 1'b0 || o_rdy !== 1'b1) begin
                errors++;
                $display("FAIL zero_vec%0d got vld=%b rdy=%b want 0 1", k, o_vld, o_rdy);
            end
            tick();
        end
        offer(8'hFF);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            checks++;
            if (o_vld !== 1'b1 || o_idx !== W'(k) || o_last !== (k == N - 1)) begin
                errors++;
                $display("FAIL ones_beat%0d got vld=%b idx=%0d last=%b want 1 %0d %b",
                         k, o_vld, o_idx, o_last, k, (k == N - 1));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL ones_done got vld=%b want 0", o_vld);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        i_rdy = 1'b1;
        offer(8'b1000_0000);
        i_vld = 1'b1;
        i_vec = 8'b0000_0001;
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b1 || o_idx !== 3'd7 || o_last !== 1'b1 || o_rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last got vld=%b idx=%0d last=%b rdy=%b want 1 7 1 1",
                     o_vld, o_idx, o_last, o_rdy);
        end
        tick();
        i_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b1 || o_idx !== 3'd0 || o_last !== 1'b1) begin
            errors++;
            $display("FAIL b2b_next got vld=%b idx=%0d last=%b want 1 0 1", o_vld, o_idx, o_last);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done got vld=%b want 0", o_vld);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int stale;
        i_rdy = 1'b1;
        offer(8'b1001_0010);
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_vld !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got vld=%b busy=%b want 0 0", o_vld, o_busy);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_rdy !== 1'b1 || o_vld !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release got rdy=%b vld=%b want 1 0", o_rdy, o_vld);
        end
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            if (o_vld === 1'b1) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL rst_mid_stale got %0d beats want 0", stale);
        end
        tick();
    endtask

    // Model: every accepted vector appends its set-bit indices (ascending) to a beat queue.
    task automatic test_random;
        int          exp_idx[$];
        bit          exp_last[$];
        int          bad;
        int          budget;
        logic [N-1:0] v;
        bad = 0;
        for (int cyc = 0; cyc < 600 + 64; cyc++) begin
            if (cyc < 600) begin
                i_vld = ($urandom_range(0, 3) != 0);
                v = $urandom;
                if ($urandom_range(0, 7) == 0) v = '0;
                i_vec = v;
                i_rdy = ($urandom_range(0, 3) != 0);
            end else begin
                i_vld = 1'b0;
                i_rdy = 1'b1;
            end
            @(negedge clk);
            checks++;
            if (o_vld !== (exp_idx.size() != 0) || o_busy !== o_vld ||
                o_rdy !== (exp_idx.size() == 0 || (exp_idx.size() == 1 && i_rdy))) begin
                bad++;
                errors++;
                $display("FAIL rand_ctl cyc=%0d got vld=%b busy=%b rdy=%b want vld=%0d pending=%0d",
                         cyc, o_vld, o_busy, o_rdy, exp_idx.size() != 0, exp_idx.size());
            end else if (o_vld === 1'b1) begin
                checks++;
                if (o_idx !== W'(exp_idx[0]) || o_last !== exp_last[0]) begin
                    errors++;
                    $display("FAIL rand_beat cyc=%0d got idx=%0d last=%b want %0d %b",
                             cyc, o_idx, o_last, exp_idx[0], exp_last[0]);
                end
                if (i_rdy) begin
                    void'(exp_idx.pop_front());
                    void'(exp_last.pop_front());
                end
            end
            if (bad > 5) break;
            if (i_vld && o_rdy) begin
                for (int b = 0; b < N; b++) begin
                    if (i_vec[b]) begin
                        exp_idx.push_back(b);
                        exp_last.push_back((i_vec >> (b + 1)) == '0);
                    end
                end
            end
            tick();
        end
        budget = exp_idx.size();
        checks++;
        if (budget != 0) begin
            errors++;
            $display("FAIL rand_drain got %0d beats outstanding want 0", budget);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        i_vld  = 1'b0;
        i_vec  = '0;
        i_rdy  = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero_then_ones();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
